// File: rtl/risc_pkg.sv
// risc_pkg: definitions shared by the fetch and decode stages.
//   - fetch_state_e : fetch FSM states (BOOT / RUN / HALT)
//   - PC_W_DEF, INST_W_DEF, HALT_WORD_DEF : default widths and halt encoding
//   - sat_inc16     : saturating 16-bit increment used by the fetch counter
package risc_pkg;

  localparam int          PC_W_DEF      = 10;
  localparam int          INST_W_DEF    = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = 16'hFFFF;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register (valid, pc, instruction).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load           : capture {1, d_pc, d_ir}
//   flush          : clear valid (wins over load); pc/ir keep their values
//   d_pc, d_ir     : captured address and instruction
//   valid, pc, ir  : registered outputs
// With neither load nor flush the register holds (stall).
module if_id_reg
  import risc_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [INST_W-1:0] d_ir,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] ir
);

  logic              valid_r;
  logic [PC_W-1:0]   pc_r;
  logic [INST_W-1:0] ir_r;

  // Flush / load / hold of the pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
      ir_r    <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= d_pc;
      ir_r    <= d_ir;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign pc    = pc_r;
  assign ir    = ir_r;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch. Owns the PC, the BOOT/RUN/HALT FSM and
// the saturating capture counter, and feeds the IF/ID register.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : hold PC, IF/ID and counter (ignored in HALT)
//   redirect_valid/_pc    : branch/jump target; flushes IF/ID
//   pc_out                : PC register, drives instruction memory
//   ir_in                 : instruction at pc_out (combinational memory)
//   if_id_valid/_pc/_ir   : IF/ID pipeline register
//   halted                : fetch parked on the halt word
//   fetch_count           : valid captures, saturating at 16'hFFFF
module fetch_stage
  import risc_pkg::*;
#(
  parameter int                PC_W      = PC_W_DEF,
  parameter int                INST_W    = INST_W_DEF,
  parameter int                RESET_PC  = 0,
  parameter logic [INST_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   pc_out,
  input  logic [INST_W-1:0] ir_in,
  output logic              if_id_valid,
  output logic [PC_W-1:0]   if_id_pc,
  output logic [INST_W-1:0] if_id_ir,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

  fetch_state_e    state_r;
  logic [PC_W-1:0] pc_r;
  logic            halted_r;
  logic [15:0]     count_r;

  logic            load_s;
  logic            flush_s;
  logic            is_halt_s;
  logic [PC_W-1:0] pc_inc_s;

  // IF/ID control: capture only on a normal RUN edge; BOOT and HALT keep it
  // invalid, and any RUN redirect flushes.
  always_comb begin
    load_s    = 1'b0;
    flush_s   = 1'b0;
    is_halt_s = (ir_in == HALT_WORD);
    pc_inc_s  = pc_r + PC_W'(1);  // wraps modulo 2^PC_W
    case (state_r)
      ST_BOOT: flush_s = 1'b1;
      ST_RUN: begin
        if (redirect_valid) begin
          flush_s = 1'b1;
        end else if (!stall) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_HALT: flush_s = 1'b1;
      default: flush_s = 1'b1;
    endcase
  end

  // Fetch FSM with PC, halt flag and capture counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_BOOT;
      pc_r     <= RESET_PC_V;
      halted_r <= 1'b0;
      count_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          if (redirect_valid) begin
            pc_r <= redirect_pc;
          end else begin
            pc_r <= pc_r;
          end
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            pc_r <= redirect_pc;
          end else if (!stall) begin
            count_r <= sat_inc16(count_r);
            if (is_halt_s) begin
              // The halt word is captured; PC stays on it.
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pc_inc_s;
            end
          end else begin
            pc_r <= pc_r;
          end
        end
        ST_HALT: begin
          // Stall is ignored here; only a redirect (or reset) leaves HALT.
          if (redirect_valid) begin
            pc_r     <= redirect_pc;
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          state_r  <= ST_BOOT;
          pc_r     <= RESET_PC_V;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .flush (flush_s),
    .d_pc  (pc_r),
    .d_ir  (ir_in),
    .valid (if_id_valid),
    .pc    (if_id_pc),
    .ir    (if_id_ir)
  );

  assign pc_out      = pc_r;
  assign halted      = halted_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized stall/redirect phase, all compared against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = 10'd0;
  logic [9:0]  pc_out;
  logic [31:0] ir_in;
  logic        if_id_valid;
  logic [9:0]  if_id_pc;
  logic [31:0] if_id_ir;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:1023];
  int errors = 0;
  int checks = 0;

  // Behavioural model of the fetch stage.
  int          m_pc, m_ipc, m_cnt;
  bit          m_boot, m_parked, m_valid, m_halted;
  logic [31:0] m_ir;

  always #5 clk = ~clk;

  assign ir_in = mem[pc_out];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_out         (pc_out),
    .ir_in          (ir_in),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_ir       (if_id_ir),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_cnt = 0; m_ir = 32'd0;
    m_boot = 1'b1; m_parked = 1'b0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc_out"},      {22'd0, pc_out},       32'(m_pc));
    chk({tag, ".valid"},       {31'd0, if_id_valid},  {31'd0, m_valid});
    chk({tag, ".halted"},      {31'd0, halted},       {31'd0, m_halted});
    chk({tag, ".fetch_count"}, {16'd0, fetch_count},  32'(m_cnt));
    if (m_valid) begin
      chk({tag, ".if_id_pc"}, {22'd0, if_id_pc}, 32'(m_ipc));
      chk({tag, ".if_id_ir"}, if_id_ir, m_ir);
    end
  endtask

  // One clock edge: drive inputs, advance the model, sample 1 time unit later.
  task automatic cycle(input bit st, input bit rv, input int rpc, input string tag);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc[9:0];
    if (m_boot) begin
      if (rv) m_pc = rpc;
      m_boot = 1'b0;
    end else if (m_parked) begin
      m_valid = 1'b0;
      if (rv) begin
        m_pc = rpc; m_parked = 1'b0; m_halted = 1'b0;
      end
    end else if (rv) begin
      m_pc = rpc; m_valid = 1'b0;
    end else if (!st) begin
      m_valid = 1'b1;
      m_ipc   = m_pc;
      m_ir    = mem[m_pc];
      if (m_cnt < 65535) m_cnt++;
      if (m_ir == 32'hFFFF_FFFF) begin
        m_parked = 1'b1; m_halted = 1'b1;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
    mem[9] = 32'hFFFF_FFFF;
    model_reset();

    // Reset state
    #12;
    check_model("reset");
    chk("reset.pc0", {22'd0, pc_out}, 32'd0);
    chk("reset.if_id_ir", if_id_ir, 32'd0);
    chk("reset.if_id_pc", {22'd0, if_id_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    cycle(1'b0, 1'b0, 0, "boot_edge1");
    chk("boot_edge1.pc", {22'd0, pc_out}, 32'd0);
    cycle(1'b0, 1'b0, 0, "boot_edge2");
    chk("boot_edge2.ir", if_id_ir, 32'h100);
    chk("boot_edge2.pc", {22'd0, pc_out}, 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, "seq");

    // Stall at pc 4
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 0, "stall");
      chk("stall.pc_out", {22'd0, pc_out}, 32'd4);
      chk("stall.if_id_ir", if_id_ir, 32'h103);
    end
    cycle(1'b0, 1'b0, 0, "resume");
    chk("resume.if_id_ir", if_id_ir, 32'h104);
    cycle(1'b0, 1'b0, 0, "seq5");

    // Redirect beats stall
    cycle(1'b1, 1'b1, 20, "redir");
    chk("redir.valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir.pc_out", {22'd0, pc_out}, 32'd20);
    cycle(1'b0, 1'b0, 0, "redir_tgt");
    chk("redir_tgt.if_id_ir", if_id_ir, 32'h114);
    cycle(1'b0, 1'b0, 0, "seq21");
    chk("count8", {16'd0, fetch_count}, 32'd8);

    // Halt at 9
    cycle(1'b0, 1'b1, 7, "to7");
    cycle(1'b0, 1'b0, 0, "f7");
    cycle(1'b0, 1'b0, 0, "f8");
    cycle(1'b0, 1'b0, 0, "halt_cap");
    chk("halt_cap.ir", if_id_ir, 32'hFFFF_FFFF);
    chk("halt_cap.halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 0, "parked");
      chk("parked.pc_out", {22'd0, pc_out}, 32'd9);
      chk("parked.valid", {31'd0, if_id_valid}, 32'd0);
    end
    cycle(1'b0, 1'b1, 2, "unpark");
    chk("unpark.halted", {31'd0, halted}, 32'd0);
    cycle(1'b0, 1'b0, 0, "unpark_tgt");
    chk("unpark_tgt.ir", if_id_ir, 32'h102);

    // PC wrap
    cycle(1'b0, 1'b1, 1022, "to1022");
    cycle(1'b0, 1'b0, 0, "w1022");
    cycle(1'b0, 1'b0, 0, "w1023");
    chk("w1023.if_id_pc", {22'd0, if_id_pc}, 32'd1023);
    cycle(1'b0, 1'b0, 0, "w0");
    chk("w0.if_id_pc", {22'd0, if_id_pc}, 32'd0);

    // Randomized stall/redirect
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 1023)), "rand");
    end

    // Asynchronous reset in RUN at pc 5
    cycle(1'b0, 1'b1, 5, "to5");
    chk("to5.pc_out", {22'd0, pc_out}, 32'd5);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    chk("async_rst.if_id_ir", if_id_ir, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 0, "reboot1");
    cycle(1'b0, 1'b0, 0, "reboot2");
    chk("reboot2.ir", if_id_ir, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
